// File: rtl/psum_accumulator.sv
// Per-kernel wide accumulation of PE-array partial sums over a configurable
// number of beats, with a valid/ready result register and sticky error flags.

module psum_acc_lane #(
    parameter int BIT_WIDTH = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*BIT_WIDTH-1:0] i_psum,
    input  logic                   i_neg_enb,
    input  logic                   i_first,
    input  logic                   i_beat,
    output logic [ACC_WIDTH-1:0]   o_sum
);
    localparam int PW = 2 * BIT_WIDTH;

    logic [ACC_WIDTH-1:0] acc_q, acc_d, ext;

    always_comb begin
        ext   = {{(ACC_WIDTH-PW){i_neg_enb & i_psum[PW-1]}}, i_psum};
        // First beat of a group overwrites, so a cleared group needs no zeroing.
        o_sum = i_first ? ext : acc_q + ext;
        acc_d = i_beat ? o_sum : acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
endmodule

module psum_accumulator #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int REG_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2*BIT_WIDTH*NUM_KERNEL-1:0] i_psum,
    input  logic [NUM_KERNEL-1:0]             i_psum_vld,
    input  logic [CNT_WIDTH-1:0]              i_conf_acc_len,
    input  logic                              i_conf_neg_enb,
    input  logic                              i_clear,
    output logic [ACC_WIDTH*NUM_KERNEL-1:0]   o_acc,
    output logic                              o_acc_vld,
    input  logic                              i_acc_rdy,
    output logic [REG_WIDTH-1:0]              o_acc_cnt,
    output logic [REG_WIDTH-1:0]              err_acc
);
    logic [NUM_KERNEL-1:0][2*BIT_WIDTH-1:0] psum_lane;
    logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]   lane_sum;
    logic [NUM_KERNEL-1:0][ACC_WIDTH-1:0]   acc_out_q, acc_out_d;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, eff_len;
    logic                 vld_q, vld_d;
    logic [REG_WIDTH-1:0] res_cnt_q, res_cnt_d;
    logic [1:0]           err_q, err_d;
    logic                 beat, mismatch, first, last, offer, load, overrun;

    assign psum_lane = i_psum;

    always_comb begin
        beat     = (&i_psum_vld) & ~i_clear;
        mismatch = (|i_psum_vld) & ~(&i_psum_vld);
        first    = (cnt_q == '0);
        eff_len  = (i_conf_acc_len == '0) ? CNT_WIDTH'(1) : i_conf_acc_len;
        // On the opening beat the group length is the live config, not len_q.
        last     = first ? (eff_len == CNT_WIDTH'(1)) : (cnt_q == len_q - 1'b1);
        offer    = beat & last;
        load     = offer & (~vld_q | i_acc_rdy);
        overrun  = offer & vld_q & ~i_acc_rdy;

        cnt_d = cnt_q;
        len_d = len_q;
        if (i_clear)   cnt_d = '0;
        else if (beat) cnt_d = last ? '0 : cnt_q + 1'b1;
        if (beat && first) len_d = eff_len;

        acc_out_d = acc_out_q;
        vld_d     = vld_q;
        res_cnt_d = res_cnt_q;
        if (load) begin
            acc_out_d = lane_sum;
            vld_d     = 1'b1;
            res_cnt_d = res_cnt_q + 1'b1;
        end else if (vld_q && i_acc_rdy) begin
            vld_d = 1'b0;
        end

        err_d = err_q | {overrun, mismatch};
    end

    for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
        psum_acc_lane #(
            .BIT_WIDTH (BIT_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_psum    (psum_lane[k]),
            .i_neg_enb (i_conf_neg_enb),
            .i_first   (first),
            .i_beat    (beat),
            .o_sum     (lane_sum[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= CNT_WIDTH'(1);
            acc_out_q <= '0;
            vld_q     <= 1'b0;
            res_cnt_q <= '0;
            err_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            acc_out_q <= acc_out_d;
            vld_q     <= vld_d;
            res_cnt_q <= res_cnt_d;
            err_q     <= err_d;
        end
    end

    assign o_acc     = acc_out_q;
    assign o_acc_vld = vld_q;
    assign o_acc_cnt = res_cnt_q;
    assign err_acc   = {{(REG_WIDTH-2){1'b0}}, err_q};
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: each step drives one cycle of inputs,
// then checks outputs just after the rising edge against hand-computed values.

module tb_psum_accumulator;
    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  i_psum;
    logic [3:0]   i_psum_vld;
    logic [15:0]  i_conf_acc_len;
    logic         i_conf_neg_enb;
    logic         i_clear;
    logic [127:0] o_acc;
    logic         o_acc_vld;
    logic         i_acc_rdy;
    logic [31:0]  o_acc_cnt;
    logic [31:0]  err_acc;

    int n_cmp = 0;
    int n_err = 0;

    psum_accumulator dut (
        .clk            (clk),
        .rst            (rst),
        .i_psum         (i_psum),
        .i_psum_vld     (i_psum_vld),
        .i_conf_acc_len (i_conf_acc_len),
        .i_conf_neg_enb (i_conf_neg_enb),
        .i_clear        (i_clear),
        .o_acc          (o_acc),
        .o_acc_vld      (o_acc_vld),
        .i_acc_rdy      (i_acc_rdy),
        .o_acc_cnt      (o_acc_cnt),
        .err_acc        (err_acc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] p0, p1, p2, p3, input logic [3:0] v);
        i_psum     = {p3, p2, p1, p0};
        i_psum_vld = v;
        tick();
        i_psum_vld = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] lanes(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    initial begin
        rst = 1'b1; i_psum = '0; i_psum_vld = '0; i_conf_acc_len = 16'd1;
        i_conf_neg_enb = 1'b0; i_clear = 1'b0; i_acc_rdy = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_acc", o_acc, 128'd0);
        chk("rst_vld", o_acc_vld, 1'b0);
        chk("rst_cnt", o_acc_cnt, 32'd0);
        chk("rst_err", err_acc, 32'd0);

        // Signed accumulation over three beats
        i_conf_neg_enb = 1'b1; i_conf_acc_len = 16'd3;
        beat(16'd10, 16'd1, 16'd1, 16'd1, 4'hF);
        beat(16'd20, 16'd1, 16'd1, 16'd1, 4'hF);
        chk("signed_vld_early", o_acc_vld, 1'b0);
        beat(16'hFFFB, 16'd1, 16'd1, 16'd1, 4'hF);
        chk("signed_vld", o_acc_vld, 1'b1);
        chk("signed_acc", o_acc, lanes(32'd25, 32'd3, 32'd3, 32'd3));
        chk("signed_cnt", o_acc_cnt, 32'd1);
        tick();
        chk("signed_drain_vld", o_acc_vld, 1'b0);
        chk("signed_drain_hold", o_acc, lanes(32'd25, 32'd3, 32'd3, 32'd3));

        // Unsigned, length 0 acts as 1
        i_conf_neg_enb = 1'b0; i_conf_acc_len = 16'd0;
        beat(16'hFFFF, 16'd0, 16'd0, 16'd0, 4'hF);
        chk("len0_acc", o_acc, lanes(32'h0000FFFF, 32'd0, 32'd0, 32'd0));
        chk("len0_vld", o_acc_vld, 1'b1);
        chk("len0_cnt", o_acc_cnt, 32'd2);
        beat(16'd2, 16'd0, 16'd0, 16'd0, 4'hF);
        chk("len0_second", o_acc, lanes(32'd2, 32'd0, 32'd0, 32'd0));
        chk("len0_cnt2", o_acc_cnt, 32'd3);
        tick();

        // Backpressure overrun
        i_conf_acc_len = 16'd1; i_acc_rdy = 1'b0;
        beat(16'd7, 16'd0, 16'd0, 16'd0, 4'hF);
        chk("ovr_first", o_acc, lanes(32'd7, 32'd0, 32'd0, 32'd0));
        beat(16'd9, 16'd0, 16'd0, 16'd0, 4'hF);
        chk("ovr_hold", o_acc, lanes(32'd7, 32'd0, 32'd0, 32'd0));
        chk("ovr_vld", o_acc_vld, 1'b1);
        chk("ovr_err", err_acc, 32'h2);
        chk("ovr_cnt", o_acc_cnt, 32'd4);
        i_acc_rdy = 1'b1;
        tick();
        chk("ovr_drain", o_acc_vld, 1'b0);

        // Valid mismatch, from a clean state
        do_reset();
        i_conf_acc_len = 16'd2;
        beat(16'd5, 16'd0, 16'd0, 16'd0, 4'hF);
        beat(16'd100, 16'd0, 16'd0, 16'd0, 4'b0111);
        chk("mis_vld_early", o_acc_vld, 1'b0);
        beat(16'd6, 16'd0, 16'd0, 16'd0, 4'hF);
        chk("mis_acc", o_acc, lanes(32'd11, 32'd0, 32'd0, 32'd0));
        chk("mis_err", err_acc, 32'h1);
        tick();

        // Clear mid-group; the beat alongside the clear is dropped too
        i_conf_acc_len = 16'd4;
        beat(16'd3, 16'd3, 16'd3, 16'd3, 4'hF);
        beat(16'd3, 16'd3, 16'd3, 16'd3, 4'hF);
        i_clear = 1'b1;
        beat(16'd50, 16'd50, 16'd50, 16'd50, 4'hF);
        i_clear = 1'b0;
        for (int i = 0; i < 3; i++) beat(16'd1, 16'd1, 16'd1, 16'd1, 4'hF);
        chk("clr_vld_early", o_acc_vld, 1'b0);
        beat(16'd1, 16'd1, 16'd1, 16'd1, 4'hF);
        chk("clr_acc", o_acc, lanes(32'd4, 32'd4, 32'd4, 32'd4));
        chk("clr_cnt", o_acc_cnt, 32'd2);
        chk("clr_err", err_acc, 32'h1);
        tick();

        // Reset mid-group
        beat(16'd1, 16'd1, 16'd1, 16'd1, 4'hF);
        beat(16'd1, 16'd1, 16'd1, 16'd1, 4'hF);
        do_reset();
        chk("rmid_acc", o_acc, 128'd0);
        chk("rmid_vld", o_acc_vld, 1'b0);
        chk("rmid_cnt", o_acc_cnt, 32'd0);
        chk("rmid_err", err_acc, 32'd0);
        for (int i = 0; i < 3; i++) beat(16'd2, 16'd2, 16'd2, 16'd2, 4'hF);
        chk("rmid_vld_early", o_acc_vld, 1'b0);
        beat(16'd2, 16'd2, 16'd2, 16'd2, 4'hF);
        chk("rmid_fresh", o_acc, lanes(32'd8, 32'd8, 32'd8, 32'd8));
        tick();

        // Back-to-back drain and load
        do_reset();
        i_conf_acc_len = 16'd1;
        for (int i = 1; i <= 3; i++) begin
            beat(16'(i), 16'd0, 16'd0, 16'd0, 4'hF);
            chk("b2b_vld", o_acc_vld, 1'b1);
            chk("b2b_acc", o_acc, lanes(32'(i), 32'd0, 32'd0, 32'd0));
        end
        chk("b2b_cnt", o_acc_cnt, 32'd3);
        chk("b2b_err", err_acc, 32'd0);
        tick();
        chk("b2b_drain", o_acc_vld, 1'b0);

        // Signed wrap and sign extension at the lane boundary
        i_conf_neg_enb = 1'b1; i_conf_acc_len = 16'd2;
        beat(16'h8000, 16'hFFFF, 16'h7FFF, 16'd0, 4'hF);
        beat(16'h8000, 16'd1, 16'd1, 16'd0, 4'hF);
        chk("sext_acc", o_acc, lanes(32'hFFFF0000, 32'd0, 32'h00008000, 32'd0));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
